pipeline_control_unit: RTL and testbench
========================================

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 255, max MEM_WAIT cycles before error (range 1..65535).
REQ-002 SHALL have ports clk (in, 1, rising-edge clock) and reset_n (in, 1, async active-low reset); one clock, reset asynchronous and active-low.
REQ-003 SHALL have id_rs1_addr, id_rs2_addr (in, 5 each, ID-stage source registers); id_rs1_used, id_rs2_used (in, 1 each, operand read valid).
REQ-004 SHALL have ex_reg_wr_addr (in, 5, EX destination), ex_is_load (in, 1, EX instruction loads memory), ex_branch_taken (in, 1, EX redirects PC).
REQ-005 SHALL have mem_req_i (in, 1, MEM-stage load/store present), dmem_ready_i (in, 1, data memory completes access this cycle).
REQ-006 SHALL have pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o (out, 1 each, register load enables).
REQ-007 SHALL have if_id_flush_o, id_ex_flush_o, mem_wb_flush_o (out, 1 each, load bubble instead of data).
REQ-008 SHALL have dmem_req_o (out, 1), stall_cnt_o (out, 32, stall cycles), error_o (out, 1, sticky timeout).

Function
REQ-009 SHALL implement FSM states INIT, RUN, MEM_WAIT, ERROR; outputs decoded from state plus current inputs.
REQ-010 INIT SHALL drive all enables 0, all flushes 1, dmem_req_o 0, and go to RUN next cycle unconditionally.
REQ-011 RUN, no event: all enables 1, all flushes 0.
REQ-012 RUN, mem_req_i=1, dmem_ready_i=0: all enables 0, mem_wb_flush_o=1, go MEM_WAIT, wait counter cleared.
REQ-013 RUN, mem_req_i=1, dmem_ready_i=1: no stall; treated as no-event for memory.
REQ-014 MEM_WAIT: all enables 0, mem_wb_flush_o=1, other flushes 0; wait counter increments each cycle.
REQ-015 MEM_WAIT, dmem_ready_i=1: go RUN; that same cycle outputs equal RUN decode (enables 1 subject to REQ-016..018).
REQ-016 MEM_WAIT, counter reaching WAIT_TIMEOUT with dmem_ready_i=0: go ERROR; ready in the same cycle wins over timeout.
REQ-017 Load-use hazard (RUN or MEM_WAIT exit cycle): ex_is_load=1, ex_reg_wr_addr!=0, and (id_rs1_used and rs1 match) or (id_rs2_used and rs2 match) -> pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, ex_mem_en_o=1, mem_wb_en_o=1.
REQ-018 Branch taken (RUN or exit cycle): pc_en_o=1, if_id_flush_o=1, id_ex_flush_o=1; overrides load-use.
REQ-019 Priority SHALL be: ERROR > memory stall > branch flush > load-use > normal.
REQ-020 dmem_req_o SHALL equal mem_req_i in RUN and MEM_WAIT, 0 in INIT and ERROR.
REQ-021 ERROR: all enables 0, flushes 0, error_o=1; exit only by reset.
REQ-022 stall_cnt_o SHALL increment by 1 on each cycle in RUN or MEM_WAIT with pc_en_o=0; saturates at 0xFFFFFFFF.
REQ-023 Register x0 SHALL never produce a hazard.

Reset
REQ-024 reset_n low SHALL asynchronously force state INIT, wait counter 0, stall_cnt_o 0, error_o 0; outputs then per REQ-010.
REQ-025 Reset asserted mid MEM_WAIT or ERROR SHALL abandon the access; dmem_req_o goes 0 immediately.

Structure
REQ-026 State encoding and default WAIT_TIMEOUT SHALL live in the shared pipeline package.
REQ-027 Hazard comparison SHALL be one sub-module, hazard_detect (combinational, rs/rd compare only).
REQ-028 All state, counter and error registers SHALL be in one async-reset always block.

Verification
REQ-029 Release reset -> first cycle INIT (enables 0, flushes 1), second cycle RUN all enables 1, stall_cnt_o=0.
REQ-030 ex_is_load=1, ex_reg_wr_addr=5, id_rs1_addr=5, id_rs1_used=1 for 1 cycle -> pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, stall_cnt_o=1; same with addr 0 -> no stall.
REQ-031 mem_req_i=1, dmem_ready_i low 3 cycles then high -> 3 cycles MEM_WAIT all enables 0, RUN on 4th, stall_cnt_o=3.
REQ-032 Load-use plus ex_branch_taken same cycle -> pc_en_o=1, if_id_flush_o=1, id_ex_flush_o=1.
REQ-033 WAIT_TIMEOUT=4, dmem_ready_i held 0 -> ERROR after 4 wait cycles, error_o=1, dmem_req_o=0, held until reset_n pulse.
REQ-034 reset_n low during MEM_WAIT -> dmem_req_o 0 same cycle, stall_cnt_o 0, INIT on release.

Source files
------------

// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipeline control unit: FSM state encoding,
// default memory wait timeout, counter widths and the stage-control bundle.
package pipeline_control_unit_pkg;

  // Default number of MEM_WAIT cycles tolerated before declaring an error.
  localparam int unsigned DEFAULT_WAIT_TIMEOUT = 255;

  // Wait counter must hold any legal timeout value (1..65535).
  localparam int unsigned WAIT_CNT_W  = 16;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERROR    = 2'd3
  } pcu_state_t;

  // Per-stage register controls driven by the unit.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  // Everything frozen, every stage register loads a bubble.
  localparam pipe_ctrl_t CTRL_INIT = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
    mem_wb_en: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1,
    mem_wb_flush: 1'b1
  };

  // Normal flow: every stage advances, nothing flushed.
  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
    mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0,
    mem_wb_flush: 1'b0
  };

  // Memory stall: whole pipe frozen, MEM/WB receives a bubble so the
  // incomplete access never retires.
  localparam pipe_ctrl_t CTRL_MEM_STALL = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
    mem_wb_en: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0,
    mem_wb_flush: 1'b1
  };

  // Error: everything frozen and nothing flushed.
  localparam pipe_ctrl_t CTRL_ERROR = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
    mem_wb_en: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0,
    mem_wb_flush: 1'b0
  };

endpackage

// File: rtl/pipeline_control_unit_hazard_detect.sv
// Register-address comparator for load-use hazards: reports when an ID-stage
// source operand that is actually read matches the EX-stage destination.
// Register x0 is hard-wired to zero and never reports a match.
module hazard_detect
  import pipeline_control_unit_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic                  i_rs1_used,
  input  logic                  i_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  output logic                  o_match
);

  logic w_rd_nonzero;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rd_nonzero = (i_rd_addr != '0);
  assign w_rs1_hit    = i_rs1_used && (i_rs1_addr == i_rd_addr);
  assign w_rs2_hit    = i_rs2_used && (i_rs2_addr == i_rd_addr);
  assign o_match      = w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline control unit: sequences reset initialisation, data-memory wait
// stalls with timeout, branch flushes and load-use stalls for a 5-stage pipe.
// Outputs are decoded from the current state plus the current inputs.
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = DEFAULT_WAIT_TIMEOUT
)
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [REG_ADDR_W-1:0]  id_rs1_addr,
  input  logic [REG_ADDR_W-1:0]  id_rs2_addr,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [REG_ADDR_W-1:0]  ex_reg_wr_addr,
  input  logic                   ex_is_load,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req_i,
  input  logic                   dmem_ready_i,
  output logic                   pc_en_o,
  output logic                   if_id_en_o,
  output logic                   id_ex_en_o,
  output logic                   ex_mem_en_o,
  output logic                   mem_wb_en_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_flush_o,
  output logic                   mem_wb_flush_o,
  output logic                   dmem_req_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   error_o
);

  // One extra bit so "count + 1" can be compared against the timeout
  // without wrapping.
  typedef logic [WAIT_CNT_W:0] wait_ext_t;

  // Saturating stall-counter increment; the counter sticks at all-ones.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(
    input logic [STALL_CNT_W-1:0] v
  );
    if (&v) begin
      return v;
    end
    return v + STALL_CNT_W'(1);
  endfunction

  pcu_state_t              r_state;
  pcu_state_t              w_next_state;
  logic [WAIT_CNT_W-1:0]   r_wait_cnt;
  logic [STALL_CNT_W-1:0]  r_stall_cnt;
  logic                    r_error;

  logic                    w_rs_match;
  logic                    w_load_use;
  logic                    w_wait_clr;
  logic                    w_wait_inc;
  logic                    w_wait_last;
  logic                    w_active;
  logic                    w_dmem_req;
  wait_ext_t               w_wait_next;
  pipe_ctrl_t              w_run_ctrl;
  pipe_ctrl_t              w_ctrl;

  hazard_detect u_hazard_detect (
    .i_rs1_addr (id_rs1_addr),
    .i_rs2_addr (id_rs2_addr),
    .i_rs1_used (id_rs1_used),
    .i_rs2_used (id_rs2_used),
    .i_rd_addr  (ex_reg_wr_addr),
    .o_match    (w_rs_match)
  );

  // A match only matters when the EX instruction is a load whose data is
  // not yet available for forwarding.
  assign w_load_use = ex_is_load && w_rs_match;

  // Timeout fires when this MEM_WAIT cycle would bring the count to the limit.
  assign w_wait_next = wait_ext_t'(r_wait_cnt) + wait_ext_t'(1);
  assign w_wait_last = (w_wait_next >= wait_ext_t'(WAIT_TIMEOUT));

  // Flow decode used whenever the pipe may move: branch beats load-use.
  always_comb begin
    w_run_ctrl = CTRL_RUN;
    if (ex_branch_taken) begin
      w_run_ctrl.pc_en       = 1'b1;
      w_run_ctrl.if_id_flush = 1'b1;
      w_run_ctrl.id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      w_run_ctrl.pc_en       = 1'b0;
      w_run_ctrl.if_id_en    = 1'b0;
      w_run_ctrl.id_ex_flush = 1'b1;
    end
  end

  // Next-state and output decode; memory stall outranks the flow decode.
  always_comb begin
    w_next_state = r_state;
    w_ctrl       = CTRL_ERROR;
    w_dmem_req   = 1'b0;
    w_wait_clr   = 1'b0;
    w_wait_inc   = 1'b0;
    w_active     = 1'b0;
    unique case (r_state)
      S_INIT: begin
        w_ctrl       = CTRL_INIT;
        w_next_state = S_RUN;
      end
      S_RUN: begin
        w_active   = 1'b1;
        w_dmem_req = mem_req_i;
        if (mem_req_i && !dmem_ready_i) begin
          w_ctrl       = CTRL_MEM_STALL;
          w_wait_clr   = 1'b1;
          w_next_state = S_MEM_WAIT;
        end else begin
          w_ctrl = w_run_ctrl;
        end
      end
      S_MEM_WAIT: begin
        w_active   = 1'b1;
        w_dmem_req = mem_req_i;
        w_wait_inc = 1'b1;
        if (dmem_ready_i) begin
          // Access completes: this cycle already behaves like RUN.
          w_ctrl       = w_run_ctrl;
          w_next_state = S_RUN;
        end else begin
          w_ctrl = CTRL_MEM_STALL;
          if (w_wait_last) begin
            w_next_state = S_ERROR;
          end
        end
      end
      S_ERROR: begin
        w_ctrl       = CTRL_ERROR;
        w_next_state = S_ERROR;
      end
      default: begin
        w_ctrl       = CTRL_INIT;
        w_next_state = S_INIT;
      end
    endcase
  end

  // State, wait counter, stall counter and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_INIT;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_wait_clr) begin
        r_wait_cnt <= '0;
      end else if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
      end
      if (w_active && !w_ctrl.pc_en) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
      if (w_next_state == S_ERROR) begin
        r_error <= 1'b1;
      end
    end
  end

  assign pc_en_o        = w_ctrl.pc_en;
  assign if_id_en_o     = w_ctrl.if_id_en;
  assign id_ex_en_o     = w_ctrl.id_ex_en;
  assign ex_mem_en_o    = w_ctrl.ex_mem_en;
  assign mem_wb_en_o    = w_ctrl.mem_wb_en;
  assign if_id_flush_o  = w_ctrl.if_id_flush;
  assign id_ex_flush_o  = w_ctrl.id_ex_flush;
  assign mem_wb_flush_o = w_ctrl.mem_wb_flush;
  assign dmem_req_o     = w_dmem_req;
  assign stall_cnt_o    = r_stall_cnt;
  assign error_o        = r_error;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit with a short memory timeout.
module tb_pipeline_control_unit;

  // Control vector order: pc, if_id, id_ex, ex_mem, mem_wb enables,
  // if_id, id_ex, mem_wb flushes, dmem_req, error.
  localparam logic [9:0] E_INIT = 10'b00000_111_0_0;
  localparam logic [9:0] E_RUN0 = 10'b11111_000_0_0;
  localparam logic [9:0] E_RUN1 = 10'b11111_000_1_0;
  localparam logic [9:0] E_MS1  = 10'b00000_001_1_0;
  localparam logic [9:0] E_LU0  = 10'b00111_010_0_0;
  localparam logic [9:0] E_LU1  = 10'b00111_010_1_0;
  localparam logic [9:0] E_BR0  = 10'b11111_110_0_0;
  localparam logic [9:0] E_ERR  = 10'b00000_000_0_1;

  logic        clk;
  logic        reset_n;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  ex_reg_wr_addr;
  logic        ex_is_load;
  logic        ex_branch_taken;
  logic        mem_req_i;
  logic        dmem_ready_i;
  logic        pc_en_o;
  logic        if_id_en_o;
  logic        id_ex_en_o;
  logic        ex_mem_en_o;
  logic        mem_wb_en_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        mem_wb_flush_o;
  logic        dmem_req_o;
  logic [31:0] stall_cnt_o;
  logic        error_o;
  logic [9:0]  w_obs;

  typedef struct {
    string       tag;
    logic [9:0]  ctl;
    logic [31:0] stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;

  pipeline_control_unit #(.WAIT_TIMEOUT(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_reg_wr_addr  (ex_reg_wr_addr),
    .ex_is_load      (ex_is_load),
    .ex_branch_taken (ex_branch_taken),
    .mem_req_i       (mem_req_i),
    .dmem_ready_i    (dmem_ready_i),
    .pc_en_o         (pc_en_o),
    .if_id_en_o      (if_id_en_o),
    .id_ex_en_o      (id_ex_en_o),
    .ex_mem_en_o     (ex_mem_en_o),
    .mem_wb_en_o     (mem_wb_en_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .mem_wb_flush_o  (mem_wb_flush_o),
    .dmem_req_o      (dmem_req_o),
    .stall_cnt_o     (stall_cnt_o),
    .error_o         (error_o)
  );

  assign w_obs = {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
                  if_id_flush_o, id_ex_flush_o, mem_wb_flush_o,
                  dmem_req_o, error_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic step(input string tag, input logic rstn,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic ld, input logic br, input logic mreq,
                      input logic rdy, input logic [9:0] ectl,
                      input logic [31:0] estall);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n         = rstn;
    id_rs1_addr     = rs1;
    id_rs2_addr     = rs2;
    id_rs1_used     = u1;
    id_rs2_used     = u2;
    ex_reg_wr_addr  = rd;
    ex_is_load      = ld;
    ex_branch_taken = br;
    mem_req_i       = mreq;
    dmem_ready_i    = rdy;
    e.tag   = tag;
    e.ctl   = ectl;
    e.stall = estall;
    sb_q.push_back(e);
  endtask

  // Compare queued expectations mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq({e.tag, "_ctl"}, 32'(w_obs), 32'(e.ctl));
      check_eq({e.tag, "_stall"}, stall_cnt_o, e.stall);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset_n         = 1'b0;
    id_rs1_addr     = '0;
    id_rs2_addr     = '0;
    id_rs1_used     = 1'b0;
    id_rs2_used     = 1'b0;
    ex_reg_wr_addr  = '0;
    ex_is_load      = 1'b0;
    ex_branch_taken = 1'b0;
    mem_req_i       = 1'b0;
    dmem_ready_i    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_ctl", 32'(w_obs), 32'(E_INIT));
    check_eq("rst_stall", stall_cnt_o, 32'd0);
    check_eq("rst_err", 32'(error_o), 32'd0);

    // Reset release, idle, load-use and x0 cases
    step("init",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_INIT, 0);
    step("run",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN0, 0);
    step("lu_rs1",    1, 5, 0, 1, 0, 5, 1, 0, 0, 0, E_LU0,  0);
    step("after_lu",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN0, 1);
    step("lu_x0",     1, 0, 0, 1, 0, 0, 1, 0, 0, 0, E_RUN0, 1);
    step("lu_rs2",    1, 5, 5, 0, 1, 5, 1, 0, 0, 0, E_LU0,  1);
    step("rs1_unusd", 1, 5, 7, 0, 1, 5, 1, 0, 0, 0, E_RUN0, 2);
    step("not_load",  1, 5, 0, 1, 0, 5, 0, 0, 0, 0, E_RUN0, 2);
    step("lu_branch", 1, 5, 0, 1, 0, 5, 1, 1, 0, 0, E_BR0,  2);
    step("mem_ready", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN1, 2);

    // Three-cycle memory stall, then completion
    step("mw_enter",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  2);
    step("mw_1",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  3);
    step("mw_2",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  4);
    step("mw_done",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN1, 5);
    step("run2",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN0, 5);

    // Load-use on the wait exit cycle
    step("mw2_enter", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  5);
    step("mw2_lu",    1, 9, 0, 1, 0, 9, 1, 0, 1, 1, E_LU1,  6);
    step("run3",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN0, 7);

    // Ready on the would-be timeout cycle wins
    step("mw3_enter", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  7);
    step("mw3_1",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  8);
    step("mw3_2",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  9);
    step("mw3_3",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  10);
    step("mw3_rdy",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN1, 11);
    step("run4",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN0, 11);

    // Timeout after four wait cycles, error is sticky
    step("to_enter",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  11);
    step("to_1",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  12);
    step("to_2",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  13);
    step("to_3",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  14);
    step("to_4",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  15);
    step("err_1",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_ERR,  16);
    step("err_rdy",   1, 5, 0, 1, 0, 5, 1, 1, 1, 1, E_ERR,  16);

    // Asynchronous reset out of ERROR
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("err_rst_ctl", 32'(w_obs), 32'(E_INIT));
    check_eq("err_rst_stall", stall_cnt_o, 32'd0);
    step("err_init",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_INIT, 0);
    step("err_run",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN0, 0);

    // Asynchronous reset in the middle of a memory wait
    step("mw4_enter", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  0);
    step("mw4_1",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MS1,  1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("mw_rst_req", 32'(dmem_req_o), 32'd0);
    check_eq("mw_rst_ctl", 32'(w_obs), 32'(E_INIT));
    check_eq("mw_rst_stall", stall_cnt_o, 32'd0);
    step("mw_init",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_INIT, 0);
    step("mw_run",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN0, 0);

    @(negedge clk);
    #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
